// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter
// Round-robin arbiter and sequencer that lets NUM_REQ requesters share a
// single 64-bit SPI transaction engine. Each grant runs exactly one
// complete exchange. The received word is returned together with a
// one-cycle done pulse to the owner.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to build a per-transfer
// watchdog. When it expires, the transfer is abandoned, rdata reads 0,
// done still pulses, and err is raised until the next grant. Without the
// macro, err is tied to 0 and START/RUN wait indefinitely.
module spi_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    I_CLK,
    input  logic                    I_RESETN,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*64-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [63:0]             rdata,
    output logic                    err,
    output logic                    busy,
    output logic                    eng_start,
    output logic [63:0]             eng_out,
    input  logic [63:0]             eng_in,
    input  logic                    eng_status
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RUN,
        DONE
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;
    logic [NUM_REQ-1:0] pick_onehot;
    logic [63:0]        pick_word;
    logic               in_xfer;
    logic               grant_now;
    logic               timeout_hit;

    assign in_xfer   = (state == START) || (state == RUN);
    assign grant_now = (state == IDLE) && pick_found;

    // Round-robin winner: scan from farthest to nearest after 'last' so the nearest pending requester overwrites
    always_comb begin
        pick_found  = 1'b0;
        pick_idx    = '0;
        cand        = '0;
        pick_onehot = '0;
        pick_word   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_onehot[i] = pick_found;
                pick_word      = req_wdata[64*i +: 64];
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    logic [15:0] wd_cnt;

    assign timeout_hit = in_xfer && (({1'b0, wd_cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));

    // Watchdog counter restarts at every grant and counts cycles spent waiting on the engine
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            wd_cnt <= '0;
        end else if (grant_now) begin
            wd_cnt <= '0;
        end else if (in_xfer) begin
            wd_cnt <= wd_cnt + 16'd1;
        end
    end

    // Error flag is raised by an expired watchdog and only cleared by the next grant
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            err <= 1'b0;
        end else if (grant_now) begin
            err <= 1'b0;
        end else if (timeout_hit) begin
            err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // Transfer sequencer: grant, hold start until the engine reports busy, wait for completion, then release
    always_ff @(posedge I_CLK or negedge I_RESETN) begin
        if (!I_RESETN) begin
            state     <= IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            gnt       <= '0;
            done      <= '0;
            rdata     <= '0;
            busy      <= 1'b0;
            eng_start <= 1'b0;
            eng_out   <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        gnt       <= pick_onehot;
                        eng_out   <= pick_word;
                        last      <= pick_idx;
                        busy      <= 1'b1;
                        eng_start <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (timeout_hit) begin
                        eng_start <= 1'b0;
                        rdata     <= '0;
                        done      <= gnt;
                        state     <= DONE;
                    end else if (eng_status) begin
                        eng_start <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (timeout_hit) begin
                        rdata <= '0;
                        done  <= gnt;
                        state <= DONE;
                    end else if (!eng_status) begin
                        rdata <= eng_in;
                        done  <= gnt;
                        state <= DONE;
                    end
                end
                DONE: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter
// Self-checking bench for spi_xfer_arbiter with a behavioural SPI engine
// that echoes the inverted outgoing word after a programmable latency.
// Expected grants come from the round-robin rule applied to the pending
// request set; expected read data is the bitwise inverse of the word that
// the granted requester offered.
module tb_spi_xfer_arbiter;

    localparam int NREQ = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*64-1:0] req_wdata;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [63:0]        rdata;
    logic               err;
    logic               busy;
    logic               eng_start;
    logic [63:0]        eng_out;
    logic [63:0]        eng_in;
    logic               eng_status;
    logic               eng_status_m;
    logic               stuck_mode;

    int          asserts    = 0;
    int          failures   = 0;
    int          done_count = 0;
    int          mdl_last   = NREQ - 1;
    int          eng_lat    = 4;
    int          eng_cnt;
    logic        eng_busy;
    logic [63:0] eng_cap;

    always #5 clk = ~clk;

    assign eng_status = stuck_mode | eng_status_m;

    spi_xfer_arbiter #(
        .NUM_REQ        (NREQ),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .I_CLK      (clk),
        .I_RESETN   (rst_n),
        .req        (req),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .busy       (busy),
        .eng_start  (eng_start),
        .eng_out    (eng_out),
        .eng_in     (eng_in),
        .eng_status (eng_status)
    );

    // Engine model: accepts a start when idle, stays busy for eng_lat cycles, then returns ~out
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_status_m <= 1'b0;
            eng_in       <= '0;
            eng_busy     <= 1'b0;
            eng_cnt      <= 0;
            eng_cap      <= '0;
        end else if (!eng_busy) begin
            if (eng_start) begin
                eng_busy     <= 1'b1;
                eng_status_m <= 1'b1;
                eng_cap      <= eng_out;
                eng_cnt      <= eng_lat;
            end
        end else if (eng_cnt <= 1) begin
            eng_busy     <= 1'b0;
            eng_status_m <= 1'b0;
            eng_in       <= ~eng_cap;
        end else begin
            eng_cnt <= eng_cnt - 1;
        end
    end

    // Continuous protocol monitor: gnt one-hot or zero, and done only ever pulses to the current owner
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            asserts++;
            if ($countones(gnt) > 1) begin
                failures++;
                $display("[TB] FAIL gnt_onehot: gnt=%b required one-hot or zero", gnt);
            end
            if (done != '0) begin
                done_count++;
                asserts++;
                if (done !== gnt) begin
                    failures++;
                    $display("[TB] FAIL done_owner: done=%b required gnt=%b", done, gnt);
                end
            end
        end
    end

    // Global safety net so the run can never hang
    initial begin
        #900000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "[TB] global timeout");
    end

    // Round-robin reference: first pending index after 'last', wrapping around
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        for (int k = 1; k <= NREQ; k++) begin
            if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        mdl_last = NREQ - 1;
        @(negedge clk);
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && gnt != '0; i++) @(negedge clk);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req        = '0;
        req_wdata  = '0;
        stuck_mode = 1'b0;
        eng_lat    = 4;
        @(negedge clk);
        asserts++;
        if ({gnt, done, err, busy, eng_start} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: gnt=%b done=%b err=%b busy=%b eng_start=%b required all 0",
                     gnt, done, err, busy, eng_start);
        end
        asserts++;
        if (rdata !== 64'd0 || eng_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: rdata=%h eng_out=%h required 0", rdata, eng_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        asserts++;
        if (busy !== 1'b0 || gnt !== '0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: busy=%b gnt=%b required 0/0000", busy, gnt);
        end
    endtask

    task automatic test_single();
        logic [63:0] word;
        bit          ok;
        word    = 64'hDEAD_BEEF_0123_4567;
        eng_lat = 40;
        @(negedge clk);
        req                    = 4'b0100;
        req_wdata[128 +: 64]   = word;
        @(posedge clk);
        @(negedge clk);
        asserts++;
        if (gnt !== 4'b0100 || busy !== 1'b1 || eng_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_grant: gnt=%b busy=%b eng_start=%b required 0100/1/1", gnt, busy, eng_start);
        end
        asserts++;
        if (eng_out !== word) begin
            failures++;
            $display("[TB] FAIL single_eng_out: eng_out=%h required %h", eng_out, word);
        end
        req_wdata[128 +: 64] = {$urandom, $urandom};
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (eng_status === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        asserts++;
        if (!ok || eng_start !== 1'b1) begin
            failures++;
            $display("[TB] FAIL single_start_hold: status_seen=%0d eng_start=%b required 1/1", ok, eng_start);
        end
        @(negedge clk);
        asserts++;
        if (eng_start !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_start_drop: eng_start=%b required 0", eng_start);
        end
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (eng_status === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        asserts++;
        if (!ok || done !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL single_done: status_low_seen=%0d done=%b required 1/0100", ok, done);
        end
        asserts++;
        if (rdata !== 64'h2152_4110_FEDC_BA98) begin
            failures++;
            $display("[TB] FAIL single_rdata: rdata=%h required 2152_4110_fedc_ba98", rdata);
        end
        req = '0;
        @(negedge clk);
        asserts++;
        if (gnt !== '0 || busy !== 1'b0 || done !== '0) begin
            failures++;
            $display("[TB] FAIL single_release: gnt=%b busy=%b done=%b required 0000/0/0000", gnt, busy, done);
        end
        mdl_last = 2;
    endtask

    task automatic test_round_robin();
        logic [63:0] words [NREQ];
        int          exp_idx;
        int          start_done;
        bit          ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            words[i]               = {$urandom, $urandom};
            req_wdata[64*i +: 64]  = words[i];
        end
        start_done = done_count;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            eng_lat = $urandom_range(1, 12);
            wait_grant(50, ok);
            exp_idx = rr_pick(mdl_last, req);
            asserts++;
            if (!ok || gnt !== (4'b0001 << exp_idx)) begin
                failures++;
                $display("[TB] FAIL rr_grant_%0d: gnt=%b required %b", n, gnt, 4'b0001 << exp_idx);
            end
            mdl_last = exp_idx;
            wait_done(200, ok);
            asserts++;
            if (!ok || rdata !== ~words[exp_idx]) begin
                failures++;
                $display("[TB] FAIL rr_rdata_%0d: rdata=%h required %h", n, rdata, ~words[exp_idx]);
            end
            if (n == 4) req = '0;
        end
        repeat (5) @(negedge clk);
        asserts++;
        if (done_count - start_done !== 5) begin
            failures++;
            $display("[TB] FAIL rr_done_count: dones=%0d required 5", done_count - start_done);
        end
    endtask

    task automatic test_drop_after_grant();
        logic [63:0] word;
        int          regrants;
        bit          ok;
        word                 = {$urandom, $urandom};
        req_wdata[64 +: 64]  = word;
        eng_lat              = $urandom_range(3, 10);
        req                  = 4'b0010;
        wait_grant(50, ok);
        asserts++;
        if (!ok || gnt !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL drop_grant: gnt=%b required 0010", gnt);
        end
        req[1] = 1'b0;
        wait_done(200, ok);
        asserts++;
        if (!ok || done !== 4'b0010 || rdata !== ~word) begin
            failures++;
            $display("[TB] FAIL drop_done: done=%b rdata=%h required 0010/%h", done, rdata, ~word);
        end
        mdl_last = 1;
        @(negedge clk);
        regrants = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt != '0) regrants++;
        end
        asserts++;
        if (regrants !== 0) begin
            failures++;
            $display("[TB] FAIL drop_no_regrant: grant_cycles=%0d required 0", regrants);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] w0;
        logic [63:0] w3;
        int          start_done;
        bit          ok;
        eng_lat               = 50;
        req_wdata[128 +: 64]  = {$urandom, $urandom};
        req                   = 4'b0100;
        wait_grant(50, ok);
        for (int i = 0; i < 20 && eng_status !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        start_done = done_count;
        rst_n = 1'b0;
        req   = '0;
        #1;
        asserts++;
        if ({gnt, done, err, busy, eng_start} !== '0 || rdata !== 64'd0 || eng_out !== 64'd0) begin
            failures++;
            $display("[TB] FAIL midrun_reset: gnt=%b done=%b err=%b busy=%b start=%b rdata=%h eng_out=%h required all 0",
                     gnt, done, err, busy, eng_start, rdata, eng_out);
        end
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        mdl_last = NREQ - 1;
        repeat (10) @(negedge clk);
        asserts++;
        if (done_count !== start_done) begin
            failures++;
            $display("[TB] FAIL midrun_no_done: dones=%0d required 0", done_count - start_done);
        end
        w0                   = {$urandom, $urandom};
        w3                   = {$urandom, $urandom};
        req_wdata[0 +: 64]   = w0;
        req_wdata[192 +: 64] = w3;
        eng_lat              = $urandom_range(1, 8);
        req                  = 4'b1001;
        wait_grant(50, ok);
        asserts++;
        if (!ok || gnt !== (4'b0001 << rr_pick(mdl_last, 4'b1001))) begin
            failures++;
            $display("[TB] FAIL midrun_first_grant: gnt=%b required 0001", gnt);
        end
        mdl_last = 0;
        wait_done(200, ok);
        asserts++;
        if (!ok || rdata !== ~w0) begin
            failures++;
            $display("[TB] FAIL midrun_rdata0: rdata=%h required %h", rdata, ~w0);
        end
        req[0] = 1'b0;
        wait_grant(50, ok);
        asserts++;
        if (!ok || gnt !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL midrun_second_grant: gnt=%b required 1000", gnt);
        end
        wait_done(200, ok);
        asserts++;
        if (!ok || rdata !== ~w3) begin
            failures++;
            $display("[TB] FAIL midrun_rdata3: rdata=%h required %h", rdata, ~w3);
        end
        req      = '0;
        mdl_last = 3;
        repeat (3) @(negedge clk);
    endtask

`ifdef SPI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] word;
        int          cycles;
        bit          ok;
        eng_lat    = 4;
        stuck_mode = 1'b1;
        req        = 4'b0010;
        wait_grant(50, ok);
        cycles = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cycles++;
            if (done != '0) break;
        end
        asserts++;
        if (cycles !== 100 || done !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL timeout_latency: cycles=%0d done=%b required 100/0010", cycles, done);
        end
        asserts++;
        if (rdata !== 64'd0 || err !== 1'b1) begin
            failures++;
            $display("[TB] FAIL timeout_flags: rdata=%h err=%b required 0/1", rdata, err);
        end
        req        = '0;
        stuck_mode = 1'b0;
        repeat (3) @(negedge clk);
        word                 = {$urandom, $urandom};
        req_wdata[128 +: 64] = word;
        req                  = 4'b0100;
        wait_grant(50, ok);
        asserts++;
        if (!ok || err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_err_clear: err=%b required 0", err);
        end
        wait_done(200, ok);
        asserts++;
        if (!ok || rdata !== ~word) begin
            failures++;
            $display("[TB] FAIL timeout_recover: rdata=%h required %h", rdata, ~word);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask
`else
    task automatic test_stuck_status();
        int  busy_bad;
        int  err_bad;
        int  done_seen;
        bit  ok;
        eng_lat    = 4;
        stuck_mode = 1'b1;
        req        = 4'b0001;
        wait_grant(50, ok);
        asserts++;
        if (!ok) begin
            failures++;
            $display("[TB] FAIL stuck_grant: gnt=%b required nonzero", gnt);
        end
        busy_bad  = 0;
        err_bad   = 0;
        done_seen = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_bad++;
            if (err !== 1'b0) err_bad++;
            if (done != '0) done_seen++;
        end
        asserts++;
        if (busy_bad !== 0) begin
            failures++;
            $display("[TB] FAIL stuck_busy: cycles_not_busy=%0d required 0", busy_bad);
        end
        asserts++;
        if (err_bad !== 0) begin
            failures++;
            $display("[TB] FAIL stuck_err: cycles_err_high=%0d required 0", err_bad);
        end
        asserts++;
        if (done_seen !== 0) begin
            failures++;
            $display("[TB] FAIL stuck_done: done_pulses=%0d required 0", done_seen);
        end
        stuck_mode = 1'b0;
        do_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_drop_after_grant();
        test_reset_mid_run();
`ifdef SPI_ARB_TIMEOUT_EN
        test_timeout();
`else
        test_stuck_status();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/spi_xfer_arbiter.md
# spi_xfer_arbiter

Round-robin arbiter and sequencer that shares one 64-bit SPI transaction engine (start / out / in / status handshake) between `NUM_REQ` requesters. It sits between the requester logic and the 64-bit master wrapper and owns the engine's `start` and `out` inputs. The engine handles one transfer at a time. Each granted requester gets one complete 64-bit exchange, and the received word is returned with a completion pulse.

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 65535: watchdog limit per transfer, 16-bit. Used only with `SPI_ARB_TIMEOUT_EN`.

- `I_CLK`, in, 1: single clock. All logic is on the rising edge.
- `I_RESETN`, in, 1: asynchronous, active-low reset.
- `req`, in, `NUM_REQ`: per-requester level request. Held until the matching `done`.
- `req_wdata`, in, `NUM_REQ*64`: requester i word in bits [64i+63:64i]. Stable while `req[i]` is high.
- `gnt`, out, `NUM_REQ`: one-hot owner of the engine. All zero when idle.
- `done`, out, `NUM_REQ`: one-cycle pulse to the owner when its transfer ends.
- `rdata`, out, 64: received word. Valid in the `done` cycle and held until the next capture.
- `err`, out, 1: timeout flag. Driven 0 when the macro is absent.
- `busy`, out, 1: high in every state except IDLE.
- `eng_start`, out, 1: engine start strobe.
- `eng_out`, out, 64: word sent to the engine.
- `eng_in`, in, 64: word received from the engine.
- `eng_status`, in, 1: engine busy flag.

## Operation
- States:
  - IDLE: if any `req` is high, pick a winner by round-robin, register `gnt` and `eng_out` = winner's `req_wdata`, then go to START.
  - START: drive `eng_start`=1 until `eng_status`=1 is sampled, then drop `eng_start` and go to RUN.
  - RUN: wait for `eng_status`=0. Then load `rdata` from `eng_in`, pulse `done[owner]`, and go to DONE.
  - DONE: clear `gnt`, go to IDLE.
- Round-robin:
  - Pointer `last` holds the last granted index.
  - Search order is `last+1`, `last+2`, …, wrapping modulo `NUM_REQ`.
  - `last` updates on each grant.
  - Reset value is `NUM_REQ-1`, so requester 0 wins first.
- `eng_out` is registered at grant and stays frozen until the next grant. Later changes to `req_wdata` are ignored.
- Dropping `req[owner]` after the grant does not abort the transfer. It runs to completion and `done` still pulses.
- A `req` that stays high after its `done` is arbitrated again normally. Other pending requesters win first.
- Reset asserted mid-transfer:
  - All outputs clear immediately: `gnt`, `done`, `rdata`, `err`, `busy`, `eng_start`, `eng_out` all 0.
  - `last` returns to `NUM_REQ-1` and state returns to IDLE.
  - No `done` is issued for the aborted transfer.

## Timing
- Every output is registered, and every output's reset value is 0.
- Sequence for a request raised at the edge before cycle 0:
  - Cycle 0: IDLE samples `req`.
  - Cycle 1: `gnt`, `eng_out` and `busy` are valid, and `eng_start`=1.
  - `eng_start` deasserts in the cycle after `eng_status`=1 is sampled.
- Completion:
  - `done` and `rdata` appear one cycle after `eng_status` is sampled low.
  - `gnt` falls one cycle after `done`.
- Minimum gap between two grants is 2 cycles (the DONE and IDLE states).
- Arbiter overhead per transfer is 4 cycles plus the engine's own latency.
- Simultaneous requests in IDLE resolve in a single cycle.
- A `req` arriving during the DONE cycle is seen in the following IDLE.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears at grant and increments each cycle in START and RUN.
  - When it reaches `TIMEOUT_CYCLES`:
    - drop `eng_start`;
    - set `rdata` = 0, pulse `done[owner]`, set `err` = 1;
    - go to DONE.
  - `err` stays high until the next grant.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter is built and `err` is constant 0.
  - START and RUN wait indefinitely.

## Test plan
- Single requester: reset, then `req[2]`=1 with `req_wdata[2]`=64'hDEAD_BEEF_0123_4567, and a model engine that echoes ~out after 40 cycles.
  - Required: `gnt`=4'b0100 at cycle 1, `eng_start` high until `eng_status` rises.
  - Required: `done[2]` pulses with `rdata`=64'h2152_4110_FEDC_BA98.
- All four requesters held high:
  - Required: grant order 0, 1, 2, 3, 0.
  - Required: exactly one `done` per transfer, and `gnt` always one-hot or zero.
- `req[1]` dropped in the cycle after its grant:
  - Required: the transfer completes, `done[1]` pulses, and no re-grant to 1 follows.
- `I_RESETN` pulsed low while in RUN:
  - Required: all outputs 0 on the same edge, no `done`.
  - Required: the next request from 3 and 0 together grants 0 first.
- With `SPI_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, and `eng_status` stuck at 1:
  - Required: `done[owner]` at grant+100 cycles with `rdata`=0 and `err`=1.
  - Required: `err` clears on the next grant.
- Without the macro, `eng_status` stuck at 1 for 10000 cycles:
  - Required: `busy` stays 1, `err` stays 0, and no `done` is issued.
